// File: rtl/sha1_digest_serializer_if.sv
// Digest-in / word-stream-out bundle between sha1_exec, the serializer and the result FIFO.
// master = the serializer (sources the word stream); slave = its environment.
interface sha1_digest_serializer_if;
    logic         out_valid_i;
    logic [159:0] cv_next_i;
    logic         m_valid_o;
    logic         m_ready_i;
    logic [31:0]  m_data_o;
    logic         m_last_o;

    modport master (
        input  out_valid_i,
        input  cv_next_i,
        input  m_ready_i,
        output m_valid_o,
        output m_data_o,
        output m_last_o
    );

    modport slave (
        output out_valid_i,
        output cv_next_i,
        output m_ready_i,
        input  m_valid_o,
        input  m_data_o,
        input  m_last_o
    );
endinterface

// File: rtl/sha1_digest_serializer.sv
// Captures a 160-bit SHA-1 chaining value on sha1_exec's out_valid pulse and streams it out
// as DIGEST_WORDS 32-bit words (H0 first) over valid/ready, with optional per-word byte swap.
module sha1_digest_serializer #(
    parameter int DIGEST_WORDS = 5,
    parameter bit BYTE_SWAP    = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    sha1_digest_serializer_if.master     bus,
    output logic                         busy_o,
    output logic                         overrun_o,
    input  logic                         clr_overrun_i
);

    localparam int         CAP_W    = 32 * DIGEST_WORDS;
    localparam logic [2:0] LAST_IDX = 3'(DIGEST_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [CAP_W-1:0]   cap_q, cap_d;
    logic               overrun_q, overrun_d;
    logic               xfer;
    logic               final_xfer;
    logic [31:0]        word_sel;

    assign xfer       = (state_q == SEND) && bus.m_ready_i;
    assign final_xfer = xfer && (idx_q == LAST_IDX);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap_d     = cap_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.out_valid_i) begin
                    state_d = SEND;
                    cap_d   = bus.cv_next_i;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (final_xfer) begin
                    // A digest arriving on the last-word transfer chains straight on, no bubble.
                    if (bus.out_valid_i) begin
                        cap_d = bus.cv_next_i;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Set is evaluated after clear so a simultaneous overrun wins.
        if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
        if ((state_q == SEND) && bus.out_valid_i && !final_xfer) begin
            overrun_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // The capture register is reset too: m_data_o must read zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cap_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_q     <= cap_d;
            overrun_q <= overrun_d;
        end
    end

    // idx is not advanced on the final transfer, so the last word stays on m_data_o while idle.
    always_comb begin
        word_sel = '0;
        for (int w = 0; w < DIGEST_WORDS; w++) begin
            if (idx_q == 3'(w)) begin
                word_sel = cap_q[CAP_W-32-32*w +: 32];
            end
        end
    end

    generate
        if (BYTE_SWAP) begin : g_swap
            assign bus.m_data_o = {word_sel[7:0], word_sel[15:8], word_sel[23:16], word_sel[31:24]};
        end else begin : g_pass
            assign bus.m_data_o = word_sel;
        end
    endgenerate

    assign bus.m_valid_o = (state_q == SEND);
    assign bus.m_last_o  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign busy_o        = (state_q == SEND);
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_sha1_digest_serializer.sv
// Directed bench for sha1_digest_serializer: a pass-through instance and a byte-swapping
// instance share the same stimulus; each scenario task checks its own expected words.
module tb_sha1_digest_serializer;

    localparam logic [159:0] D1 = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
    localparam logic [159:0] D2 = {32'hDA39A3EE, 32'h5E6B4B0D, 32'h3255BFEF, 32'h95601890, 32'hAFD80709};

    logic [31:0] d1_w  [5] = '{32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
    logic [31:0] d2_w  [5] = '{32'hDA39A3EE, 32'h5E6B4B0D, 32'h3255BFEF, 32'h95601890, 32'hAFD80709};
    logic [31:0] d1_sw [5] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 32'hF0E1D2C3};

    logic clk = 1'b0;
    logic reset;
    logic clr_overrun;
    logic busy_a, overrun_a, busy_b, overrun_b;

    int n_checks = 0;
    int n_fail   = 0;

    sha1_digest_serializer_if aif ();
    sha1_digest_serializer_if bif ();

    assign bif.out_valid_i = aif.out_valid_i;
    assign bif.cv_next_i   = aif.cv_next_i;
    assign bif.m_ready_i   = aif.m_ready_i;

    sha1_digest_serializer #(.DIGEST_WORDS(5), .BYTE_SWAP(1'b0)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (aif),
        .busy_o        (busy_a),
        .overrun_o     (overrun_a),
        .clr_overrun_i (clr_overrun)
    );

    sha1_digest_serializer #(.DIGEST_WORDS(5), .BYTE_SWAP(1'b1)) u_dut_swap (
        .clk           (clk),
        .reset         (reset),
        .bus           (bif),
        .busy_o        (busy_b),
        .overrun_o     (overrun_b),
        .clr_overrun_i (clr_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    // Stimulus is applied and outputs sampled on the falling edge.
    task automatic test_reset();
        reset              = 1'b1;
        clr_overrun        = 1'b0;
        aif.out_valid_i    = 1'b0;
        aif.cv_next_i      = '0;
        aif.m_ready_i      = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({aif.m_valid_o, aif.m_last_o, aif.m_data_o, busy_a, overrun_a} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b l=%b d=%h busy=%b ovr=%b, required all zero",
                     aif.m_valid_o, aif.m_last_o, aif.m_data_o, busy_a, overrun_a);
        end
        n_checks++;
        if ({bif.m_valid_o, bif.m_last_o, bif.m_data_o, busy_b, overrun_b} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b l=%b d=%h busy=%b ovr=%b, required all zero",
                     bif.m_valid_o, bif.m_last_o, bif.m_data_o, busy_b, overrun_b);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        aif.m_ready_i   = 1'b1;
        aif.cv_next_i   = D1;
        aif.out_valid_i = 1'b1;
        @(negedge clk);
        aif.out_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({aif.m_valid_o, aif.m_last_o, aif.m_data_o, busy_a} !== {1'b1, (k == 4), d1_w[k], 1'b1}) begin
                n_fail++;
                $display("FAIL basic_word%0d: got v=%b l=%b d=%h busy=%b, required v=1 l=%b d=%h busy=1",
                         k, aif.m_valid_o, aif.m_last_o, aif.m_data_o, busy_a, (k == 4), d1_w[k]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({aif.m_valid_o, busy_a, aif.m_last_o, aif.m_data_o} !== {3'b000, 32'hC3D2E1F0}) begin
            n_fail++;
            $display("FAIL basic_idle: got v=%b busy=%b l=%b d=%h, required v=0 busy=0 l=0 d=c3d2e1f0",
                     aif.m_valid_o, busy_a, aif.m_last_o, aif.m_data_o);
        end
    endtask

    task automatic test_backpressure();
        int  k;
        int  cyc;
        logic r;
        aif.m_ready_i   = 1'b0;
        aif.cv_next_i   = D1;
        aif.out_valid_i = 1'b1;
        @(negedge clk);
        aif.out_valid_i = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < 5 && cyc < 40) begin
            n_checks++;
            if ({aif.m_valid_o, aif.m_last_o, aif.m_data_o} !== {1'b1, (k == 4), d1_w[k]}) begin
                n_fail++;
                $display("FAIL bp_cycle%0d: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                         cyc, aif.m_valid_o, aif.m_last_o, aif.m_data_o, (k == 4), d1_w[k]);
            end
            r             = (cyc % 3 == 0);
            aif.m_ready_i = r;
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        aif.m_ready_i = 1'b0;
        n_checks++;
        if ({aif.m_valid_o, busy_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_idle: got v=%b busy=%b, required v=0 busy=0", aif.m_valid_o, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        aif.m_ready_i   = 1'b1;
        aif.cv_next_i   = D1;
        aif.out_valid_i = 1'b1;
        @(negedge clk);
        aif.out_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({aif.m_valid_o, aif.m_last_o, aif.m_data_o} !== {1'b1, (k == 4), d1_w[k]}) begin
                n_fail++;
                $display("FAIL b2b_first_word%0d: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                         k, aif.m_valid_o, aif.m_last_o, aif.m_data_o, (k == 4), d1_w[k]);
            end
            if (k == 4) begin
                aif.cv_next_i   = D2;
                aif.out_valid_i = 1'b1;
            end
            @(negedge clk);
        end
        aif.out_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({aif.m_valid_o, aif.m_last_o, aif.m_data_o} !== {1'b1, (k == 4), d2_w[k]}) begin
                n_fail++;
                $display("FAIL b2b_second_word%0d: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                         k, aif.m_valid_o, aif.m_last_o, aif.m_data_o, (k == 4), d2_w[k]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({aif.m_valid_o, overrun_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_end: got v=%b ovr=%b, required v=0 ovr=0", aif.m_valid_o, overrun_a);
        end
        aif.m_ready_i = 1'b0;
    endtask

    task automatic test_overrun();
        aif.m_ready_i   = 1'b1;
        aif.cv_next_i   = D1;
        aif.out_valid_i = 1'b1;
        @(negedge clk);
        aif.out_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({aif.m_valid_o, aif.m_last_o, aif.m_data_o} !== {1'b1, (k == 4), d1_w[k]}) begin
                n_fail++;
                $display("FAIL ovr_word%0d: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                         k, aif.m_valid_o, aif.m_last_o, aif.m_data_o, (k == 4), d1_w[k]);
            end
            if (k == 3) begin
                n_checks++;
                if (overrun_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovr_set: got overrun=%b, required 1", overrun_a);
                end
            end
            aif.out_valid_i = (k == 2);
            aif.cv_next_i   = (k == 2) ? D2 : '0;
            @(negedge clk);
        end
        aif.out_valid_i = 1'b0;
        n_checks++;
        if ({aif.m_valid_o, overrun_a} !== 2'b01) begin
            n_fail++;
            $display("FAIL ovr_sticky: got v=%b ovr=%b, required v=0 ovr=1", aif.m_valid_o, overrun_a);
        end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        n_checks++;
        if (overrun_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: got overrun=%b, required 0", overrun_a);
        end

        // Stalled stream: raise overrun, then clear and set together.
        aif.m_ready_i   = 1'b0;
        aif.cv_next_i   = D1;
        aif.out_valid_i = 1'b1;
        @(negedge clk);
        aif.cv_next_i   = D2;
        @(negedge clk);
        clr_overrun     = 1'b1;
        @(negedge clk);
        aif.out_valid_i = 1'b0;
        clr_overrun     = 1'b0;
        n_checks++;
        if (overrun_a !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set_wins: got overrun=%b, required 1", overrun_a);
        end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        n_checks++;
        if (overrun_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear2: got overrun=%b, required 0", overrun_a);
        end
        aif.m_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({aif.m_valid_o, aif.m_last_o, aif.m_data_o} !== {1'b1, (k == 4), d1_w[k]}) begin
                n_fail++;
                $display("FAIL ovr_stall_word%0d: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                         k, aif.m_valid_o, aif.m_last_o, aif.m_data_o, (k == 4), d1_w[k]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (aif.m_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_stall_idle: got v=%b, required 0", aif.m_valid_o);
        end
        aif.m_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        aif.m_ready_i   = 1'b1;
        aif.cv_next_i   = D1;
        aif.out_valid_i = 1'b1;
        @(negedge clk);
        aif.out_valid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({aif.m_valid_o, aif.m_data_o} !== {1'b1, d1_w[k]}) begin
                n_fail++;
                $display("FAIL rst_mid_word%0d: got v=%b d=%h, required v=1 d=%h",
                         k, aif.m_valid_o, aif.m_data_o, d1_w[k]);
            end
            if (k == 1) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        n_checks++;
        if ({aif.m_valid_o, busy_a, aif.m_last_o, aif.m_data_o} !== 35'h0) begin
            n_fail++;
            $display("FAIL rst_mid_cleared: got v=%b busy=%b l=%b d=%h, required all zero",
                     aif.m_valid_o, busy_a, aif.m_last_o, aif.m_data_o);
        end
        aif.cv_next_i   = D2;
        aif.out_valid_i = 1'b1;
        @(negedge clk);
        aif.out_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({aif.m_valid_o, aif.m_last_o, aif.m_data_o} !== {1'b1, (k == 4), d2_w[k]}) begin
                n_fail++;
                $display("FAIL rst_mid_new_word%0d: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                         k, aif.m_valid_o, aif.m_last_o, aif.m_data_o, (k == 4), d2_w[k]);
            end
            @(negedge clk);
        end
        aif.m_ready_i = 1'b0;
    endtask

    task automatic test_byte_swap();
        aif.m_ready_i   = 1'b1;
        aif.cv_next_i   = D1;
        aif.out_valid_i = 1'b1;
        @(negedge clk);
        aif.out_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({bif.m_valid_o, bif.m_last_o, bif.m_data_o} !== {1'b1, (k == 4), d1_sw[k]}) begin
                n_fail++;
                $display("FAIL swap_word%0d: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                         k, bif.m_valid_o, bif.m_last_o, bif.m_data_o, (k == 4), d1_sw[k]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({bif.m_valid_o, busy_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL swap_idle: got v=%b busy=%b, required v=0 busy=0", bif.m_valid_o, busy_b);
        end
        aif.m_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid_stream();
        test_byte_swap();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
